// File: rtl/pipeline_defs.sv
// ---------------------------------------------------------------------------
// pipeline_defs
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS
// pipeline: fetch FSM state type and encodings, instruction size, default
// reset PC and a word-alignment helper.
// ---------------------------------------------------------------------------
package pipeline_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    // Plain vector encodings of the fetch states, used for the state register
    // so older tools and waveform scripts see a simple 2-bit field.
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_FETCH   = FETCH;
    localparam logic [1:0] ST_HOLD    = HOLD;
    localparam logic [1:0] ST_DISCARD = DISCARD;

    localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Branch targets come from decode's adder; the low two bits carry no
    // meaning for a word-aligned instruction stream and are forced to zero.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request bus between the fetch stage and instruction
// memory.
//   imem_req   : request valid, held with imem_addr stable until imem_ready
//   imem_addr  : word-aligned fetch address
//   imem_ready : one-cycle pulse, imem_data valid and request complete
//   imem_data  : instruction word
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );

endinterface

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
// Combinational next-PC logic for the fetch stage.
// Inputs : state, pc, pending_pc, branch_taken, branch_target, imem_ready,
//          stall
// Outputs: pc_next         - value the PC register takes at the next edge
//          pending_pc_next - redirect address remembered while a stale
//                            request is being drained
//          pc_plus_four    - pc + 4 (modulo 2^32), also used for IF/ID
// Priority: branch_taken > imem_ready > stall.
// ---------------------------------------------------------------------------
module pc_next_calc
    import pipeline_defs::*;
(
    input  logic [1:0]  state,
    input  logic [31:0] pc,
    input  logic [31:0] pending_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ready,
    input  logic        stall,
    output logic [31:0] pc_next,
    output logic [31:0] pending_pc_next,
    output logic [31:0] pc_plus_four
);

    logic [31:0] target_aligned;

    always_comb begin
        target_aligned  = align_word(branch_target);
        pc_plus_four    = pc + INSTR_BYTES;
        pc_next         = pc;
        pending_pc_next = pending_pc;

        case (state)
            ST_IDLE: begin
                if (branch_taken) begin
                    pc_next = target_aligned;
                end
            end

            ST_FETCH: begin
                if (branch_taken) begin
                    // With the request completing this cycle the PC can move
                    // straight away; otherwise the outstanding request must
                    // keep its address, so the target is parked.
                    if (imem_ready) begin
                        pc_next = target_aligned;
                    end else begin
                        pending_pc_next = target_aligned;
                    end
                end else if (imem_ready && !stall) begin
                    pc_next = pc_plus_four;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    pc_next = target_aligned;
                end else if (!stall) begin
                    pc_next = pc_plus_four;
                end
            end

            ST_DISCARD: begin
                if (imem_ready) begin
                    // A redirect arriving together with the stale data is the
                    // newest one and wins over the parked target.
                    pc_next = branch_taken ? target_aligned : pending_pc;
                end else if (branch_taken) begin
                    pending_pc_next = target_aligned;
                end
            end

            default: begin
                pc_next = pc;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and fills the IF/ID slot consumed by decode.
// Ports:
//   clock, reset_n        - clock, asynchronous active-low reset
//   imem (master)         - instruction-memory request bus
//   stall                 - decode cannot take a new IF/ID entry this cycle
//   branch_taken/_target  - redirect from decode; flushes IF/ID
//   if_id_valid           - IF/ID holds a live instruction
//   if_id_instruction     - fetched word (NOP when invalid)
//   if_id_pc_plus_four    - fetch address + 4 of if_id_instruction
// States: IDLE (first cycle after reset), FETCH (request outstanding),
// HOLD (word returned while decode stalled, parked in hold_buf), DISCARD
// (redirected while a request was in flight; its data will be dropped).
// ---------------------------------------------------------------------------
module fetch_stage
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clock,
    input  logic                 reset_n,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic                 if_id_valid,
    output logic [31:0]          if_id_instruction,
    output logic [31:0]          if_id_pc_plus_four
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_instruction_q, if_id_instruction_d;
    logic [31:0] if_id_pc_plus_four_q, if_id_pc_plus_four_d;
    logic [31:0] pc_plus_four;

    pc_next_calc u_pc_next_calc (
        .state           (state_q),
        .pc              (pc_q),
        .pending_pc      (pending_pc_q),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_ready      (imem.imem_ready),
        .stall           (stall),
        .pc_next         (pc_d),
        .pending_pc_next (pending_pc_d),
        .pc_plus_four    (pc_plus_four)
    );

    always_comb begin
        state_d              = state_q;
        hold_buf_d           = hold_buf_q;
        if_id_valid_d        = if_id_valid_q;
        if_id_instruction_d  = if_id_instruction_q;
        if_id_pc_plus_four_d = if_id_pc_plus_four_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (branch_taken) begin
                    if_id_valid_d       = 1'b0;
                    if_id_instruction_d = NOP_INSTRUCTION;
                end
            end

            ST_FETCH: begin
                if (branch_taken) begin
                    if_id_valid_d       = 1'b0;
                    if_id_instruction_d = NOP_INSTRUCTION;
                    state_d             = imem.imem_ready ? ST_FETCH : ST_DISCARD;
                end else if (imem.imem_ready) begin
                    if (stall) begin
                        // Decode still owns IF/ID; park the word.
                        hold_buf_d = imem.imem_data;
                        state_d    = ST_HOLD;
                    end else begin
                        if_id_valid_d        = 1'b1;
                        if_id_instruction_d  = imem.imem_data;
                        if_id_pc_plus_four_d = pc_plus_four;
                    end
                end else if (!stall) begin
                    // Decode consumed the entry and nothing new arrived.
                    if_id_valid_d       = 1'b0;
                    if_id_instruction_d = NOP_INSTRUCTION;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    if_id_valid_d       = 1'b0;
                    if_id_instruction_d = NOP_INSTRUCTION;
                    state_d             = ST_FETCH;
                end else if (!stall) begin
                    if_id_valid_d        = 1'b1;
                    if_id_instruction_d  = hold_buf_q;
                    if_id_pc_plus_four_d = pc_plus_four;
                    state_d              = ST_FETCH;
                end
            end

            ST_DISCARD: begin
                if_id_valid_d       = 1'b0;
                if_id_instruction_d = NOP_INSTRUCTION;
                if (imem.imem_ready) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q              <= ST_IDLE;
            pc_q                 <= RESET_PC;
            pending_pc_q         <= RESET_PC;
            hold_buf_q           <= 32'h0;
            if_id_valid_q        <= 1'b0;
            if_id_instruction_q  <= NOP_INSTRUCTION;
            if_id_pc_plus_four_q <= 32'h0;
        end else begin
            state_q              <= state_d;
            pc_q                 <= pc_d;
            pending_pc_q         <= pending_pc_d;
            hold_buf_q           <= hold_buf_d;
            if_id_valid_q        <= if_id_valid_d;
            if_id_instruction_q  <= if_id_instruction_d;
            if_id_pc_plus_four_q <= if_id_pc_plus_four_d;
        end
    end

    // The request is a pure function of registered state, so it drops to
    // zero the instant reset asserts and never depends on this cycle's inputs.
    assign imem.imem_req  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign imem.imem_addr = pc_q;

    assign if_id_valid        = if_id_valid_q;
    assign if_id_instruction  = if_id_instruction_q;
    assign if_id_pc_plus_four = if_id_pc_plus_four_q;

endmodule
